// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter: FSM encoding, parity-mode codes
// and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } tx_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam logic [1:0] PAR_MARK = 2'b11;

  localparam int unsigned MaxDataBits = 9;

  // Data is zero-padded to MaxDataBits by the caller; padding does not change the XOR.
  function automatic logic parity_bit(input logic [1:0] mode,
                                      input logic [MaxDataBits-1:0] data);
    case (mode)
      PAR_EVEN: return ^data;
      PAR_ODD:  return ~^data;
      PAR_MARK: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO with occupancy count; push while full and pop while empty are
// ignored.
module uart_tx_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    push_ok  = push_i && !full_o;
    pop_ok   = pop_i && !empty_o;
    wr_ptr_d = push_ok ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata_i;
      end
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: FIFO-fed, LSB first, optional parity, 1 or 2 stop bits,
// back-to-back frames. Serial, active and done are registered from the current FSM state.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          i_Clock,
  input  logic                          i_Rst_L,
  input  logic                          i_Tx_DV,
  input  logic [DATA_BITS-1:0]          i_Tx_Byte,
  input  logic [1:0]                    i_Parity_Mode,
  output logic                          o_Tx_Ready,
  output logic                          o_Tx_Overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
  output logic                          o_Tx_Active,
  output logic                          o_Tx_Serial,
  output logic                          o_Tx_Done
);

  localparam int unsigned ClkW  = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW  = $clog2(DATA_BITS);
  localparam int unsigned StopW = $clog2(STOP_BITS * CLKS_PER_BIT);

  localparam logic [ClkW-1:0]  ClkLast  = ClkW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BITS - 1);
  localparam logic [StopW-1:0] StopLast = StopW'(STOP_BITS * CLKS_PER_BIT - 1);

  tx_state_e             state_q, state_d;
  logic [ClkW-1:0]       clk_cnt_q, clk_cnt_d;
  logic [BitW-1:0]       bit_idx_q, bit_idx_d;
  logic [StopW-1:0]      stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic [1:0]            mode_q, mode_d;
  logic                  serial_q, serial_d;
  logic                  active_q, active_d;
  logic                  overflow_q, overflow_d;
  logic                  last_stop_q;
  logic                  done_q;

  logic                   fifo_pop, fifo_full, fifo_empty, load, stop_end;
  logic [DATA_BITS-1:0]   fifo_rdata;
  logic [MaxDataBits-1:0] par_data;

  uart_tx_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (DATA_BITS)
  ) u_fifo (
    .clk_i   (i_Clock),
    .rst_ni  (i_Rst_L),
    .push_i  (i_Tx_DV),
    .wdata_i (i_Tx_Byte),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .count_o (o_Fifo_Count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign o_Tx_Ready    = !fifo_full;
  assign o_Tx_Overflow = overflow_q;
  assign o_Tx_Active   = active_q;
  assign o_Tx_Serial   = serial_q;
  assign o_Tx_Done     = done_q;

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    mode_d     = mode_q;
    fifo_pop   = 1'b0;
    load       = 1'b0;
    stop_end   = 1'b0;
    case (state_q)
      StIdle: load = !fifo_empty;
      StStart: begin
        if (clk_cnt_q == ClkLast) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = StData;
        end else begin
          clk_cnt_d = clk_cnt_q + ClkW'(1);
        end
      end
      StData: begin
        if (clk_cnt_q == ClkLast) begin
          clk_cnt_d = '0;
          if (bit_idx_q == BitLast) begin
            stop_cnt_d = '0;
            state_d    = (mode_q == PAR_NONE) ? StStop : StParity;
          end else begin
            bit_idx_d = bit_idx_q + BitW'(1);
          end
        end else begin
          clk_cnt_d = clk_cnt_q + ClkW'(1);
        end
      end
      StParity: begin
        if (clk_cnt_q == ClkLast) begin
          clk_cnt_d  = '0;
          stop_cnt_d = '0;
          state_d    = StStop;
        end else begin
          clk_cnt_d = clk_cnt_q + ClkW'(1);
        end
      end
      StStop: begin
        if (stop_cnt_q == StopLast) begin
          stop_end   = 1'b1;
          stop_cnt_d = '0;
          state_d    = StIdle;
          load       = !fifo_empty;
        end else begin
          stop_cnt_d = stop_cnt_q + StopW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    // Pop from idle or straight out of the last stop cycle, so queued frames have no gap.
    if (load) begin
      fifo_pop  = 1'b1;
      shift_d   = fifo_rdata;
      mode_d    = i_Parity_Mode;
      clk_cnt_d = '0;
      state_d   = StStart;
    end
  end

  always_comb begin
    par_data                  = '0;
    par_data[DATA_BITS-1:0]   = shift_q;
    case (state_q)
      StStart:  serial_d = 1'b0;
      StData:   serial_d = shift_q[bit_idx_q];
      StParity: serial_d = parity_bit(mode_q, par_data);
      default:  serial_d = 1'b1;
    endcase
    active_d   = (state_q != StIdle);
    overflow_d = i_Tx_DV && fifo_full;
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q     <= StIdle;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      stop_cnt_q  <= '0;
      shift_q     <= '0;
      mode_q      <= PAR_NONE;
      serial_q    <= 1'b1;
      active_q    <= 1'b0;
      overflow_q  <= 1'b0;
      last_stop_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      stop_cnt_q  <= stop_cnt_d;
      shift_q     <= shift_d;
      mode_q      <= mode_d;
      serial_q    <= serial_d;
      active_q    <= active_d;
      overflow_q  <= overflow_d;
      // Serial lags the FSM by one cycle, so done needs two stages to follow the line.
      last_stop_q <= stop_end;
      done_q      <= last_stop_q;
    end
  end

endmodule
